// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier.
//   state_t      : controller states
//   booth_sel_t  : decoded Booth digit (magnitude select + sign)
//   booth_decode : maps a {b2i+1, b2i, b2i-1} triplet to a booth_sel_t
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic single;  // select +/-A
    logic double;  // select +/-2A
    logic neg;     // negate the selected magnitude
  } booth_sel_t;

  function automatic booth_sel_t booth_decode(input logic [2:0] triplet);
    booth_sel_t sel;
    sel = '0;
    case (triplet)
      3'b001, 3'b010: sel.single = 1'b1;
      3'b011:         sel.double = 1'b1;
      3'b100: begin
        sel.double = 1'b1;
        sel.neg    = 1'b1;
      end
      3'b101, 3'b110: begin
        sel.single = 1'b1;
        sel.neg    = 1'b1;
      end
      default: ;  // 000 / 111 -> zero partial product
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// Radix-4 Booth partial-product selector (combinational).
// Ports:
//   triplet : Booth digit bits {b2i+1, b2i, b2i-1}
//   mcand   : multiplicand, W bits, already aligned to the digit position
//   pp_c    : signed partial product (0, +/-A, +/-2A), two's complement, W bits
module booth_r4_pp_gen
  import booth_pkg::*;
#(
  parameter int unsigned W = 50
) (
  input  logic [2:0]   triplet,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] pp_c
);

  booth_sel_t     sel;
  logic [W-1:0]   mag;

  // Select magnitude, then complete the negation here so the accumulator needs no carry-in.
  always_comb begin
    sel = booth_decode(triplet);
    mag = '0;
    if (sel.single) begin
      mag = mcand;
    end else if (sel.double) begin
      mag = mcand << 1;
    end
    pp_c = sel.neg ? (~mag + W'(1)) : mag;
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier for unsigned operands: one Booth digit
// retired per clock into a 2*WIDTH+2 bit accumulator; one operation in flight.
// Optional build macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero (products are identical, latency shortens).
// Ports:
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    : operand handshake, in_a (multiplicand), in_b (multiplier)
//   out_valid/out_ready  : result handshake, out_prod = in_a * in_b (registered)
//   busy                 : high while an operation is in RUN or DONE
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int unsigned NDIG = (WIDTH + 2) / 2;
  localparam int unsigned PW   = 2 * WIDTH + 2;   // accumulator / multiplicand width
  localparam int unsigned MW   = WIDTH + 3;       // multiplier shift register width
  localparam int unsigned CW   = $clog2(NDIG + 1);
  localparam int unsigned OW   = 2 * WIDTH;

  state_t          state_q,     state_d;
  logic [PW-1:0]   mcand_q,     mcand_d;
  logic [MW-1:0]   mplier_q,    mplier_d;
  logic [PW-1:0]   acc_q,       acc_d;
  logic [CW-1:0]   dig_cnt_q,   dig_cnt_d;
  logic            in_ready_q,  in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [OW-1:0]   out_prod_q,  out_prod_d;
  logic            busy_q,      busy_d;
  logic [PW-1:0]   pp_c;

  booth_r4_pp_gen #(
    .W (PW)
  ) u_pp_gen (
    .triplet (mplier_q[2:0]),
    .mcand   (mcand_q),
    .pp_c    (pp_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    dig_cnt_d   = dig_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_prod_d  = out_prod_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d    = PW'(in_a);
          mplier_d   = {2'b00, in_b, 1'b0};
          acc_d      = '0;
          dig_cnt_d  = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      RUN: begin
`ifdef BOOTH_EARLY_TERM_EN
        // Nothing left to add: the accumulator already holds the product.
        if (mplier_q == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_prod_d  = acc_q[OW-1:0];
        end else
`endif
        begin
          acc_d     = acc_q + pp_c;
          mcand_d   = mcand_q << 2;
          mplier_d  = mplier_q >> 2;
          dig_cnt_d = dig_cnt_q + CW'(1);
          if (dig_cnt_q == CW'(NDIG - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_prod_d  = acc_d[OW-1:0];  // bits above 2*WIDTH-1 are dropped
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      dig_cnt_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_prod_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      dig_cnt_q   <= dig_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign busy      = busy_q;

endmodule
